tdm_demux8: RTL and testbench
=============================

Name: tdm_demux8

Overview:
- Receiving end of our 8:1 mux selection path: takes one time-multiplexed stream and steers each beat to one of 8 registered output lanes.
- Slot order matches the mux select encoding: slot k goes to lane k, where k = {s2,s1,s0}. s2 picks the upper half (lanes 4-7).
- A frame-sync FSM aligns slot 0 to a start-of-frame marker and flags framing errors.
- Sits downstream of any mux8to1-based TDM source, so channel data can be reconstructed.

Parameters:
- W, 8, data width of the stream and of each lane.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  beat qualifier; a beat is accepted when in_valid=1 on a clk edge.
- in_sof  input  1  start of frame; meaningful only with in_valid=1; marks the beat as slot 0.
- in_data  input  W  beat payload.
- out_data  output  8*W  flat lane bus; lane k occupies bits [k*W+W-1 : k*W].
- out_lane_valid  output  8  one-cycle strobe per lane; bit k set when lane k was written.
- frame_done  output  1  one-cycle pulse when slot 7 of a locked frame is written.
- sync_err  output  1  one-cycle pulse on a framing error.
- locked  output  1  high while the FSM is in LOCKED.

Behaviour:
- Reset (async assert, sync release): out_data=0, out_lane_valid=0, frame_done=0, sync_err=0, locked=0, slot counter=0, FSM=HUNT.
- The block is always ready; there is no backpressure.
- Cycles with in_valid=0 change nothing except clearing the strobes (out_lane_valid, frame_done, sync_err) to 0.
- FSM HUNT:
  - Beats with in_sof=0 are discarded: no lane write, no strobe.
  - A beat with in_sof=1 writes lane 0, sets slot=1 and moves to LOCKED.
- FSM LOCKED:
  - Each beat writes lane[slot], then slot increments modulo 8 (7 wraps to 0).
  - in_sof=1 when slot==0 is a normal frame start: write lane 0, slot=1, stay LOCKED.
  - in_sof=1 when slot!=0 is a short frame: sync_err=1, write lane 0, slot=1, stay LOCKED. Lanes not yet written in the aborted frame keep their old values.
  - in_sof=0 when slot==0 is a missing marker: sync_err=1, beat discarded, slot stays 0, go to HUNT, locked=0 in the next cycle.
- Latency: a beat accepted at edge n makes out_data lane k, out_lane_valid[k] and (for slot 7) frame_done visible after edge n, so they are valid for one cycle.
  - At most one bit of out_lane_valid is set in any cycle.
- Lane registers hold their value until overwritten. Lanes are never cleared except by reset.
- locked reflects the registered FSM state.
- rst_n asserted mid-frame: all state and outputs clear immediately, whatever the clk state. After release the block needs a new in_sof.
- Width: the slot counter is 3 bits and wraps naturally. The W-bit payload is copied unmodified.

Test Plan:
- Reset, then in_sof on beat 0 with data 0x10..0x17 on 8 consecutive beats:
  - out_lane_valid strobes 0x01,0x02,…,0x80 on consecutive cycles.
  - out_data lane k = 0x10+k.
  - frame_done pulses once, with the 0x80 strobe.
  - locked=1 from the cycle after the first beat.
- Beats 0xAA,0xBB with in_sof=0 before any sof: no strobes, out_data stays 0, locked=0. Then an sof beat 0x01: lane0=0x01, locked=1.
- Locked, in_sof asserted at slot 3 with data 0x55:
  - sync_err pulses.
  - lane0=0x55 and lanes 3-7 keep their previous frame's values.
  - The next beat writes lane 1.
- Full frame, then next beat with in_sof=0 and data 0x99: sync_err pulses, no lane write, locked drops, and the FSM returns to HUNT.
- in_valid toggled 1,0,1,0 during a frame: slot advances only on valid beats, giving strobes 0x01,0x00,0x02,0x00.
- rst_n pulsed low between clk edges mid-frame (after lane 4 written): all outputs read 0 before the next edge. Post-release beats without in_sof are ignored.

Source files
------------

// File: rtl/tdm_demux8.sv
// tdm_demux8: frame-synchronised demultiplexer that steers a TDM beat stream onto 8 registered lanes.
// Slot k lands on lane k; a start-of-frame marker realigns slot 0 and framing faults pulse sync_err.
module tdm_demux8 #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    input  logic           in_sof,
    input  logic [W-1:0]   in_data,
    output logic [8*W-1:0] out_data,
    output logic [7:0]     out_lane_valid,
    output logic           frame_done,
    output logic           sync_err,
    output logic           locked
);
    typedef enum logic {HUNT, LOCKED} state_t;

    state_t     state, state_d;
    logic [2:0] slot, slot_d, lane;
    logic       wr, err;

    always_comb begin
        state_d = state;
        slot_d  = slot;
        wr      = 1'b0;
        err     = 1'b0;
        lane    = in_sof ? 3'd0 : slot;
        if (in_valid) begin
            if (state == HUNT) begin
                if (in_sof) begin
                    wr      = 1'b1;
                    slot_d  = 3'd1;
                    state_d = LOCKED;
                end
            end else if (in_sof) begin
                // a marker anywhere but slot 0 aborts the frame yet still starts the new one
                wr     = 1'b1;
                slot_d = 3'd1;
                err    = slot != 3'd0;
            end else if (slot == 3'd0) begin
                err     = 1'b1;
                state_d = HUNT;
            end else begin
                wr     = 1'b1;
                slot_d = slot + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= HUNT;
            slot           <= 3'd0;
            out_data       <= '0;
            out_lane_valid <= 8'd0;
            frame_done     <= 1'b0;
            sync_err       <= 1'b0;
        end else begin
            state          <= state_d;
            slot           <= slot_d;
            out_lane_valid <= wr ? (8'd1 << lane) : 8'd0;
            frame_done     <= wr && (lane == 3'd7);
            sync_err       <= err;
            if (wr) out_data[int'(lane)*W +: W] <= in_data;
        end
    end

    assign locked = state == LOCKED;
endmodule

// File: tb/tb_tdm_demux8.sv
// tb_tdm_demux8: randomized and directed scoreboard bench for tdm_demux8.
// Expected strobes are queued per accepted beat; a negedge monitor pops and compares them.
module tb_tdm_demux8;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_sof = 1'b0;
    logic [W-1:0]   in_data = '0;
    logic [8*W-1:0] out_data;
    logic [7:0]     out_lane_valid;
    logic           frame_done, sync_err, locked;

    tdm_demux8 #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
        .out_data(out_data), .out_lane_valid(out_lane_valid), .frame_done(frame_done),
        .sync_err(sync_err), .locked(locked)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] lv;
        logic       fd;
        logic       se;
    } ev_t;

    ev_t          exp_q[$];
    logic [W-1:0] m_lanes[8];
    bit           m_locked;
    int           m_slot;
    int           tests = 0;
    int           fails = 0;

    function automatic logic [8*W-1:0] model_bus();
        logic [8*W-1:0] b;
        for (int k = 0; k < 8; k++) b[k*W +: W] = m_lanes[k];
        return b;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 8; k++) m_lanes[k] = '0;
        m_locked = 0;
        m_slot   = 0;
        exp_q.delete();
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Frame rules applied to an accepted beat; lanes are an array indexed by slot number.
    task automatic model_step(input bit s, input logic [W-1:0] d);
        ev_t e;
        if (!m_locked) begin
            if (s) begin
                m_lanes[0] = d; m_slot = 1; m_locked = 1;
                e = '{lv: 8'h01, fd: 1'b0, se: 1'b0}; exp_q.push_back(e);
            end
        end else if (s) begin
            e = '{lv: 8'h01, fd: 1'b0, se: (m_slot != 0)};
            m_lanes[0] = d; m_slot = 1;
            exp_q.push_back(e);
        end else if (m_slot == 0) begin
            m_locked = 0;
            e = '{lv: 8'h00, fd: 1'b0, se: 1'b1}; exp_q.push_back(e);
        end else begin
            m_lanes[m_slot] = d;
            e = '{lv: 8'(1 << m_slot), fd: (m_slot == 7), se: 1'b0};
            exp_q.push_back(e);
            m_slot = (m_slot + 1) % 8;
        end
    endtask

    task automatic drive(input bit v, input bit s, input logic [W-1:0] d);
        in_valid = v; in_sof = s; in_data = d;
        @(posedge clk);
        #1;
        if (v) model_step(s, d);
        in_valid = 1'b0; in_sof = 1'b0;
    endtask

    always @(negedge clk) begin
        ev_t e;
        check("out_data", 64'(out_data), 64'(model_bus()));
        check("locked", 64'(locked), 64'(m_locked));
        check("onehot", 64'($countones(out_lane_valid) <= 1), 64'd1);
        if (out_lane_valid != 0 || frame_done || sync_err) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 64'({out_lane_valid, frame_done, sync_err}), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("strobes", 64'({out_lane_valid, frame_done, sync_err}), 64'(e));
            end
        end else if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("missing_strobe", 64'd0, 64'(e));
        end
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        // discarded beats before any marker, then a locking frame
        drive(1, 0, 8'hAA);
        drive(1, 0, 8'hBB);
        drive(1, 1, 8'h01);
        for (int k = 1; k < 8; k++) drive(1, 0, 8'(8'h01 + k));
        for (int k = 0; k < 8; k++) drive(1, k == 0, 8'(8'h10 + k));
        // short frame: marker at slot 3
        for (int k = 0; k < 3; k++) drive(1, k == 0, 8'(8'h20 + k));
        drive(1, 1, 8'h55);
        drive(1, 0, 8'h66);
        for (int k = 2; k < 8; k++) drive(1, 0, 8'(8'h30 + k));
        // missing marker after a full frame
        drive(1, 0, 8'h99);
        drive(0, 0, 8'h00);
        // valid gaps inside a frame, then async reset after lane 4
        drive(1, 1, 8'h40);
        for (int k = 1; k < 5; k++) begin
            drive(0, 0, 8'hEE);
            drive(1, 0, 8'(8'h40 + k));
        end
        @(negedge clk); #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_lane_valid", 64'(out_lane_valid), 64'd0);
        check("rst_locked", 64'(locked), 64'd0);
        check("rst_pulses", 64'({frame_done, sync_err}), 64'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        drive(1, 0, 8'h77);
        drive(1, 0, 8'h78);
        // randomized traffic, mostly well-formed with occasional faults
        for (int i = 0; i < 400; i++) begin
            bit v, s;
            v = ($urandom_range(0, 4) != 0);
            s = (m_slot == 0 && $urandom_range(0, 7) != 0) || ($urandom_range(0, 11) == 0);
            drive(v, s, 8'($urandom));
        end
        repeat (3) drive(0, 0, 8'h00);
        @(negedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
